// File: rtl/match_buffer.sv
// -----------------------------------------------------------------------------
// match_buffer
//
// Packet-capture FIFO placed behind a port comparator. While idle it watches
// the incoming word stream. The first valid word that the comparator flags as
// a match opens a capture: that word and every later valid word of the same
// packet (matched or not) are written, up to and including the eop word. The
// captured packet is then held, and no further writes happen until the
// consumer has drained the buffer. After that the block re-arms for the next
// match.
//
// Ports
//   clk        in   system clock, rising edge
//   n_rst      in   asynchronous active-low reset
//   clear      in   synchronous flush/abort, beats every input except n_rst
//   data_in    in   32-bit packet word from the comparator
//   data_valid in   data_in carries a valid word this cycle
//   match      in   comparator match flag, aligned with data_in
//   eop        in   current valid word is the last word of its packet
//   rd_en      in   consumer pop request
//   rd_data    out  head-of-FIFO word (first-word-fall-through)
//   empty      out  FIFO holds zero words
//   full       out  FIFO holds DEPTH words
//   count      out  number of words held
//   flagged    out  sticky: a complete matched packet has been captured
//   overflow   out  sticky: at least one word of a capture was dropped
// -----------------------------------------------------------------------------
module match_buffer #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic                         clear,
    input  logic [31:0]                  data_in,
    input  logic                         data_valid,
    input  logic                         match,
    input  logic                         eop,
    input  logic                         rd_en,
    output logic [31:0]                  rd_data,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         flagged,
    output logic                         overflow
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCapture = 2'd1,
        StHold    = 2'd2
    } state_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e          state_q,    state_d;
    logic [PtrW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [CntW-1:0] count_q,    count_d;
    logic            flagged_q,  flagged_d;
    logic            overflow_q, overflow_d;

    // Storage is deliberately left out of reset; only pointers/count matter.
    logic [31:0]     mem_q [DEPTH];

    // -------------------------------------------------------------------------
    // Datapath decode
    // -------------------------------------------------------------------------
    logic fifo_empty;
    logic fifo_full;
    logic wr_req;   // the FSM wants this word stored
    logic pop;      // a pop is actually performed
    logic push;     // a write is actually performed
    logic drop;     // a requested write is lost because the FIFO is full

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CntW'(DEPTH));

    always_comb begin
        wr_req = 1'b0;
        unique case (state_q)
            StIdle:    wr_req = data_valid & match;
            StCapture: wr_req = data_valid;
            StHold:    wr_req = 1'b0;
            default:   wr_req = 1'b0;
        endcase
    end

    // A pop in the same cycle frees the slot, so a write into a full FIFO is
    // only dropped when nothing is leaving.
    assign pop  = rd_en & ~fifo_empty & ~clear;
    assign push = wr_req & (~fifo_full | pop) & ~clear;
    assign drop = wr_req & fifo_full & ~pop & ~clear;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        flagged_d  = flagged_q;
        overflow_d = overflow_q;

        if (clear) begin
            state_d    = StIdle;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            flagged_d  = 1'b0;
            overflow_d = 1'b0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end

            unique case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase

            if (drop) begin
                overflow_d = 1'b1;
            end

            // Packet-level control; transitions happen even if the word
            // itself was dropped.
            unique case (state_q)
                StIdle: begin
                    if (data_valid && match) begin
                        if (eop) begin
                            state_d   = StHold;
                            flagged_d = 1'b1;
                        end else begin
                            state_d = StCapture;
                        end
                    end
                end
                StCapture: begin
                    if (data_valid && eop) begin
                        state_d   = StHold;
                        flagged_d = 1'b1;
                    end
                end
                StHold: begin
                    // Re-arm one edge after the consumer has drained us.
                    if (fifo_empty) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            flagged_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            flagged_q  <= flagged_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign rd_data  = mem_q[rd_ptr_q];
    assign empty    = fifo_empty;
    assign full     = fifo_full;
    assign count    = count_q;
    assign flagged  = flagged_q;
    assign overflow = overflow_q;

    // -------------------------------------------------------------------------
    // Sanity properties
    // -------------------------------------------------------------------------
    a_count_in_range: assert property (
        @(posedge clk) disable iff (!n_rst) count_q <= CntW'(DEPTH)
    );

    a_hold_no_write: assert property (
        @(posedge clk) disable iff (!n_rst) (state_q == StHold) |-> !push
    );

endmodule

// File: tb/tb_match_buffer.sv
// -----------------------------------------------------------------------------
// Bench for match_buffer. A queue-based packet model tracks which words should
// be held, the capture phase of the packet stream and the two sticky flags.
// Every DUT-visible output is compared with it after each clock edge.
// -----------------------------------------------------------------------------
module tb_match_buffer;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          n_rst;
    logic          clear;
    logic [31:0]   data_in;
    logic          data_valid;
    logic          match;
    logic          eop;
    logic          rd_en;
    logic [31:0]   rd_data;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          flagged;
    logic          overflow;

    match_buffer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .clear      (clear),
        .data_in    (data_in),
        .data_valid (data_valid),
        .match      (match),
        .eop        (eop),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .flagged    (flagged),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Reference model: packet-level view of the buffer
    // -------------------------------------------------------------------------
    typedef enum {MIdle, MCapture, MHold} mphase_e;

    logic [31:0] mq[$];
    mphase_e     mphase;
    bit          mflag;
    bit          movf;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mphase = MIdle;
        mflag  = 1'b0;
        movf   = 1'b0;
    endtask

    // Advance the model by one rising edge using the inputs present at it.
    task automatic model_edge();
        int size_before;
        bit do_pop;
        bit wants_word;
        if (clear) begin
            model_reset();
        end else begin
            size_before = mq.size();
            do_pop      = rd_en && (size_before > 0);
            wants_word  = data_valid && ((mphase == MIdle && match) || mphase == MCapture);
            if (do_pop) begin
                void'(mq.pop_front());
            end
            if (wants_word) begin
                if (size_before < int'(DEPTH) || do_pop) mq.push_back(data_in);
                else movf = 1'b1;
            end
            case (mphase)
                MIdle: begin
                    if (data_valid && match) begin
                        mphase = eop ? MHold : MCapture;
                        if (eop) mflag = 1'b1;
                    end
                end
                MCapture: begin
                    if (data_valid && eop) begin
                        mphase = MHold;
                        mflag  = 1'b1;
                    end
                end
                MHold: begin
                    if (size_before == 0) mphase = MIdle;
                end
                default: mphase = MIdle;
            endcase
        end
    endtask

    task automatic check_all(input string tag);
        check_val({tag, ".count"},    32'(count),    32'(mq.size()));
        check_val({tag, ".empty"},    32'(empty),    32'(mq.size() == 0));
        check_val({tag, ".full"},     32'(full),     32'(mq.size() == int'(DEPTH)));
        check_val({tag, ".flagged"},  32'(flagged),  32'(mflag));
        check_val({tag, ".overflow"}, 32'(overflow), 32'(movf));
        if (mq.size() > 0) begin
            check_val({tag, ".rd_data"}, rd_data, mq[0]);
        end
    endtask

    // One clock cycle of stimulus, followed by a full output check.
    task automatic step(input bit v, input bit m, input bit e, input bit rd,
                        input bit clr, input logic [31:0] d, input string tag);
        @(negedge clk);
        data_valid = v;
        match      = m;
        eop        = e;
        rd_en      = rd;
        clear      = clr;
        data_in    = d;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle_step(input string tag);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, tag);
    endtask

    task automatic flush(input string tag);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, tag);
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        logic [31:0] basic_words [3];
        basic_words[0] = 32'h00AB_CD00;
        basic_words[1] = 32'h1111_1111;
        basic_words[2] = 32'h2222_2222;

        n_rst      = 1'b0;
        clear      = 1'b0;
        data_in    = '0;
        data_valid = 1'b0;
        match      = 1'b0;
        eop        = 1'b0;
        rd_en      = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;

        // Basic capture: matched first word opens the packet.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, basic_words[0], "basic.w0");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, basic_words[1], "basic.w1");
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, basic_words[2], "basic.w2");
        check_val("basic.count3", 32'(count), 32'd3);
        check_val("basic.flagged", 32'(flagged), 32'd1);
        // Held packet: further matched traffic must not be stored.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, "basic.hold");
        check_val("basic.hold_count", 32'(count), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check_val("basic.pop_data", rd_data, basic_words[i]);
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, "basic.pop");
        end
        check_val("basic.empty", 32'(empty), 32'd1);
        // Still in the hold phase for this edge: matched word ignored.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hCAFE_0001, "basic.drain_edge");
        // Re-armed: a single-word matched packet is captured and flagged.
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'hCAFE_0002, "basic.rearm");
        check_val("basic.rearm_data", rd_data, 32'hCAFE_0002);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, "basic.rearm_pop");
        idle_step("basic.idle");

        // Filtering: unmatched packet is never stored.
        flush("filter.clear");
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, (i == 3), 1'b0, 1'b0, 32'h5000_0000 + 32'(i), "filter.w");
        end
        check_val("filter.count", 32'(count), 32'd0);
        check_val("filter.flagged", 32'(flagged), 32'd0);

        // Overflow: 10-word matched packet into an 8-deep buffer.
        flush("ovf.clear");
        for (int i = 0; i < 10; i++) begin
            step(1'b1, (i == 0), (i == 9), 1'b0, 1'b0, 32'(i), "ovf.w");
        end
        check_val("ovf.count", 32'(count), 32'(DEPTH));
        check_val("ovf.full", 32'(full), 32'd1);
        check_val("ovf.overflow", 32'(overflow), 32'd1);
        check_val("ovf.flagged", 32'(flagged), 32'd1);
        for (int i = 0; i < 8; i++) begin
            check_val("ovf.pop_data", rd_data, 32'(i));
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, "ovf.pop");
        end
        idle_step("ovf.idle");

        // Simultaneous push and pop while full in capture.
        flush("sim.clear");
        for (int i = 0; i < 8; i++) begin
            step(1'b1, (i == 0), 1'b0, 1'b0, 1'b0, 32'd100 + 32'(i), "sim.fill");
        end
        check_val("sim.full", 32'(full), 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd200, "sim.both");
        check_val("sim.count", 32'(count), 32'd8);
        check_val("sim.no_ovf", 32'(overflow), 32'd0);
        check_val("sim.head", rd_data, 32'd101);
        for (int i = 0; i < 11; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, "sim.drain");
        end
        check_val("sim.empty_count", 32'(count), 32'd0);

        // Clear beats a simultaneous write and pop.
        flush("clr.clear");
        for (int i = 0; i < 10; i++) begin
            step(1'b1, (i == 0), (i == 9), 1'b0, 1'b0, 32'h7000_0000 + 32'(i), "clr.fill");
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, "clr.pop");
        end
        check_val("clr.count5", 32'(count), 32'd5);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_0000, "clr.pulse");
        check_val("clr.count", 32'(count), 32'd0);
        check_val("clr.empty", 32'(empty), 32'd1);
        check_val("clr.flagged", 32'(flagged), 32'd0);
        check_val("clr.overflow", 32'(overflow), 32'd0);
        // Back in idle: an unmatched word is filtered.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_0001, "clr.idle");
        check_val("clr.idle_count", 32'(count), 32'd0);

        // Asynchronous reset in the middle of a capture.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hA0, "rst.w0");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hA1, "rst.w1");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hA2, "rst.w2");
        check_val("rst.count3", 32'(count), 32'd3);
        #2;
        data_valid = 1'b0;
        n_rst      = 1'b0;
        #1;
        model_reset();
        check_val("rst.async_count", 32'(count), 32'd0);
        check_val("rst.async_empty", 32'(empty), 32'd1);
        check_val("rst.async_flagged", 32'(flagged), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        // Partial packet discarded: unmatched continuation is not captured.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hA3, "rst.after");
        check_val("rst.after_count", 32'(count), 32'd0);

        // Randomized traffic, alternating drain-heavy and fill-heavy phases.
        for (int i = 0; i < 3000; i++) begin
            int rd_pct;
            rd_pct = ((i / 300) % 2 == 0) ? 60 : 10;
            step(($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 30),
                 ($urandom_range(0, 99) < 12), ($urandom_range(0, 99) < rd_pct),
                 ($urandom_range(0, 199) < 2), $urandom, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Guard against a stuck simulation.
    initial begin
        #1ms;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
